// File: rtl/eth_reg_pkg.sv
// Shared types and constants for the PHY management register path.
// Contents: FSM state encoding, PHY register addresses, address/data widths,
// the read value returned on a timed-out access, and the request payload struct.
package eth_reg_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 16;

    localparam logic [REG_DATA_W-1:0] TMO_RVAL = 16'hFFFF;

    // Standard clause-22 PHY registers
    localparam logic [REG_ADDR_W-1:0] BMCR   = 5'd0;
    localparam logic [REG_ADDR_W-1:0] BMSR   = 5'd1;
    localparam logic [REG_ADDR_W-1:0] PHYID1 = 5'd2;
    localparam logic [REG_ADDR_W-1:0] PHYID2 = 5'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ACK   = 2'd2,
        ST_HOLD  = 2'd3
    } arb_state_e;

    // One register access as presented to the MAC
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic                  write;
        logic [REG_DATA_W-1:0] wval;
    } reg_req_t;

endpackage

// File: rtl/phy_reg_arbiter_if.sv
// Bundle between the requesters/MAC and the register-port arbiter.
// Requester side: req_vld/req_addr/req_write/req_wval in, req_rval/req_ack/req_err out.
// MAC side: reg_vld/reg_addr/reg_write/reg_wval out, reg_rval/reg_ack in.
// Status: busy, grant_id.
// modport slave = arbiter view, modport master = requesters + MAC view.
interface phy_reg_arbiter_if
    import eth_reg_pkg::*;
#(
    parameter int unsigned NREQ = 4
);
    localparam int unsigned GW = $clog2(NREQ);

    logic [NREQ-1:0]            req_vld;
    logic [NREQ*REG_ADDR_W-1:0] req_addr;
    logic [NREQ-1:0]            req_write;
    logic [NREQ*REG_DATA_W-1:0] req_wval;
    logic [REG_DATA_W-1:0]      req_rval;
    logic [NREQ-1:0]            req_ack;
    logic [NREQ-1:0]            req_err;

    logic                       reg_vld;
    logic [REG_ADDR_W-1:0]      reg_addr;
    logic                       reg_write;
    logic [REG_DATA_W-1:0]      reg_wval;
    logic [REG_DATA_W-1:0]      reg_rval;
    logic                       reg_ack;

    logic                       busy;
    logic [GW-1:0]              grant_id;

    modport slave (
        input  req_vld, req_addr, req_write, req_wval, reg_rval, reg_ack,
        output req_rval, req_ack, req_err, reg_vld, reg_addr, reg_write, reg_wval,
               busy, grant_id
    );

    modport master (
        output req_vld, req_addr, req_write, req_wval, reg_rval, reg_ack,
        input  req_rval, req_ack, req_err, reg_vld, reg_addr, reg_write, reg_wval,
               busy, grant_id
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible (req & ~mask) index at or
// above ptr, wrapping at N. Works for any N, including non-powers of two.
// Ports: req_i, mask_i [N]; ptr_i [$clog2(N)]; any_c_o; idx_c_o [$clog2(N)].
module rr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [N-1:0]         mask_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic                 any_c_o,
    output logic [$clog2(N)-1:0] idx_c_o
);
    localparam int unsigned IW = $clog2(N);

    logic [N-1:0] elig_c;
    int           cand_c;

    // Scan from the farthest offset down so the nearest eligible index wins
    always_comb begin
        elig_c  = req_i & ~mask_i;
        any_c_o = 1'b0;
        idx_c_o = '0;
        cand_c  = 0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            cand_c = int'(ptr_i) + k;
            if (cand_c >= int'(N)) begin
                cand_c = cand_c - int'(N);
            end
            if (elig_c[IW'(cand_c)]) begin
                any_c_o = 1'b1;
                idx_c_o = IW'(cand_c);
            end
        end
    end

endmodule

// File: rtl/phy_reg_arbiter.sv
// Round-robin arbiter sharing the MAC PHY management register port among
// NREQ requesters, with a per-access watchdog.
// Ports: clk_mac, rst (async, active-high); bus (phy_reg_arbiter_if.slave)
// carrying the requester, MAC and status signals. All outputs registered.
module phy_reg_arbiter
    import eth_reg_pkg::*;
#(
    parameter int unsigned NREQ           = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic             clk_mac,
    input  logic             rst,
    phy_reg_arbiter_if.slave bus
);
    localparam int unsigned GW = $clog2(NREQ);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    arb_state_e            state_q;
    logic [GW-1:0]         grant_q;
    logic [GW-1:0]         rr_ptr_q;
    logic [GW-1:0]         rr_ptr_d;
    logic [TW-1:0]         tmo_cnt_q;
    reg_req_t              reg_q;
    logic                  reg_vld_q;
    logic [REG_DATA_W-1:0] req_rval_q;
    logic [NREQ-1:0]       req_ack_q;
    logic [NREQ-1:0]       req_err_q;
    logic                  busy_q;

    logic [NREQ-1:0]       hold_mask_c;
    logic                  pick_any_c;
    logic [GW-1:0]         pick_idx_c;
    reg_req_t              sel_c;

    // The just-served requester is invisible while it drops its request
    assign hold_mask_c = (state_q == ST_HOLD) ? (NREQ'(1) << grant_q) : '0;

    rr_pick #(.N(NREQ)) u_pick (
        .req_i   (bus.req_vld),
        .mask_i  (hold_mask_c),
        .ptr_i   (rr_ptr_q),
        .any_c_o (pick_any_c),
        .idx_c_o (pick_idx_c)
    );

    // Explicit wrap so non-power-of-two NREQ cycles correctly
    assign rr_ptr_d = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + GW'(1);

    // Fields of the winning requester
    always_comb begin
        sel_c = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (pick_idx_c == GW'(i)) begin
                sel_c.addr  = bus.req_addr[i*REG_ADDR_W +: REG_ADDR_W];
                sel_c.write = bus.req_write[i];
                sel_c.wval  = bus.req_wval[i*REG_DATA_W +: REG_DATA_W];
            end
        end
    end

    // Arbitration FSM with registered outputs
    always_ff @(posedge clk_mac or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            tmo_cnt_q  <= '0;
            reg_q      <= '0;
            reg_vld_q  <= 1'b0;
            req_rval_q <= '0;
            req_ack_q  <= '0;
            req_err_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            req_ack_q <= '0;
            req_err_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_any_c) begin
                        grant_q   <= pick_idx_c;
                        reg_q     <= sel_c;
                        tmo_cnt_q <= '0;
                        reg_vld_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.reg_ack) begin
                        req_rval_q <= bus.reg_rval;
                        req_ack_q  <= NREQ'(1) << grant_q;
                        reg_vld_q  <= 1'b0;
                        state_q    <= ST_ACK;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        // Watchdog: complete the access with an error
                        req_rval_q <= TMO_RVAL;
                        req_ack_q  <= NREQ'(1) << grant_q;
                        req_err_q  <= NREQ'(1) << grant_q;
                        reg_vld_q  <= 1'b0;
                        state_q    <= ST_ACK;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TW'(1);
                    end
                end
                ST_ACK: begin
                    rr_ptr_q <= rr_ptr_d;
                    state_q  <= ST_HOLD;
                end
                ST_HOLD: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.reg_vld   = reg_vld_q;
    assign bus.reg_addr  = reg_q.addr;
    assign bus.reg_write = reg_q.write;
    assign bus.reg_wval  = reg_q.wval;
    assign bus.req_rval  = req_rval_q;
    assign bus.req_ack   = req_ack_q;
    assign bus.req_err   = req_err_q;
    assign bus.busy      = busy_q;
    assign bus.grant_id  = grant_q;

endmodule

// File: doc/phy_reg_arbiter.md
# phy_reg_arbiter

Round-robin arbiter sharing the `eth_mac` PHY management register port among up to `NREQ` independent requesters, such as the link monitor, the debug LED reader and the configuration sequencer. It sits between those clients and the MAC's `reg_vld/reg_addr/reg_write/reg_wval/reg_rval/reg_ack` port in the `clk_mac` domain. It serialises accesses, routes each read value and ack back to the owning requester, and uses a watchdog so that a hung management transaction cannot lock the port.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 65535: maximum ISSUE-state cycles to wait for `reg_ack` before aborting, ≥ 16.
- `clk_mac` in 1: single clock for the block.
- `rst` in 1: reset, asynchronous, active-high.
- `req_vld` in NREQ: per-requester access request. Held with stable fields until that requester's `req_ack`.
- `req_addr` in 5·NREQ: PHY register address. Requester i uses bits [5i+4:5i].
- `req_write` in NREQ: 1 = write, 0 = read.
- `req_wval` in 16·NREQ: write data. Requester i uses bits [16i+15:16i].
- `req_rval` out 16: read data, valid only when a `req_ack` bit is high. Shared by all requesters.
- `req_ack` out NREQ: one-cycle completion pulse to the owning requester.
- `req_err` out NREQ: one-cycle pulse, coincident with `req_ack`, when the access timed out.
- `reg_vld`, `reg_addr`[5], `reg_write`, `reg_wval`[16] out: request to the MAC register port.
- `reg_rval` in 16: read data from the MAC.
- `reg_ack` in 1: one-cycle completion pulse from the MAC.
- `busy` out 1: high in every state except IDLE.
- `grant_id` out $clog2(NREQ): index of the current or last granted requester.

## Operation
- **FSM states:** IDLE, ISSUE, ACK, HOLD.
- **IDLE:**
  - Eligible requesters are those with `req_vld` set.
  - The requester in HOLD is excluded for that cycle.
  - If any are eligible, the winner is the first set bit searching upward from `rr_ptr`, wrapping around.
  - Latch `grant_id`, copy that requester's addr/write/wval into the output registers, clear `tmo_cnt`, and go to ISSUE.
- **ISSUE:**
  - `reg_vld` = 1 with stable fields.
  - On `reg_ack`: capture `reg_rval` into `req_rval` and go to ACK.
  - Otherwise, if `tmo_cnt == TIMEOUT_CYCLES-1`: set `req_rval` = 16'hFFFF, set the error flag and go to ACK.
  - Otherwise increment `tmo_cnt`.
- **ACK:**
  - Pulse `req_ack[grant_id]`; also pulse `req_err[grant_id]` if the error flag is set.
  - `reg_vld` = 0.
  - Set `rr_ptr` = (`grant_id` + 1) mod `NREQ`.
  - Go to HOLD.
- **HOLD:**
  - One cycle in which the just-served requester is masked, giving it time to drop `req_vld`.
  - Go to IDLE.
  - IDLE arbitration in the following cycle uses an unmasked `req_vld`.
- **Requester obligation:** `req_vld` is low no later than the second cycle after its `req_ack`.
- **Stale acks:** `reg_ack` arriving outside ISSUE (e.g. a late ack after a timeout) is ignored and does not change `req_rval`.
- **Dropped requests:** a requester dropping `req_vld` while granted is ignored. The access completes and is acked normally.
- **Reset, including mid-access:**
  - All outputs go to 0: `reg_vld`, `reg_write`, `reg_addr`, `reg_wval`, `req_ack`, `req_err`, `req_rval`, `busy`, `grant_id`.
  - State goes to IDLE, `rr_ptr` to 0 and `tmo_cnt` to 0.
  - An interrupted access is never acked.
- **Widths:** `tmo_cnt` is $clog2(`TIMEOUT_CYCLES`) bits. `rr_ptr` wraps modulo `NREQ`; non-power-of-2 `NREQ` requires explicit wrap logic.

## Timing
- All outputs are registered. There is no combinational path from `req_*` or `reg_ack` to any output.
- `req_vld[i]` first high in IDLE at cycle N gives `reg_vld` = 1 from cycle N+1.
- `reg_ack` at cycle M gives `req_ack` / `req_rval` at M+1 and `reg_vld` = 0 at M+1.
- Next grant: earliest at M+3 (HOLD at M+2); the next `reg_vld` is at M+4.
- Timeout: `reg_vld` is high for exactly `TIMEOUT_CYCLES` cycles, then the `req_ack`/`req_err` pulse follows.
- Fairness: with all requesters continuously requesting, each is served exactly once per `NREQ` grants.

## Structure
- **Package `eth_reg_pkg`:**
  - FSM state encoding.
  - PHY register address constants: BMCR=0, BMSR=1, PHYID1=2, PHYID2=3.
  - `REG_ADDR_W`=5, `REG_DATA_W`=16.
  - `TMO_RVAL`=16'hFFFF.
- **Sub-module `rr_pick`:** combinational. Inputs are the request vector, mask and pointer; outputs are `any` and the winner index. It is reused by future MAC TX-source arbitration.

## Test plan
- **Single read:** `req_vld[2]`, addr 1, MAC acks with 16'h782D after 5 cycles. Expect `req_ack` = 4'b0100 with `req_rval` = 16'h782D one cycle after `reg_ack`, and `reg_addr` = 1 while `reg_vld` is high.
- **Contention:** all 4 requesters request simultaneously from reset. Expect grant order 0,1,2,3,0 and HOLD spacing exactly as specified under Timing.
- **Write:** requester 1 writes 16'h3100 to addr 0. Expect `reg_write` = 1 and `reg_wval` = 16'h3100 stable until `reg_ack`, and `req_err` = 0.
- **Timeout:** `TIMEOUT_CYCLES`=16 and the MAC never acks. Expect `reg_vld` high for 16 cycles, then `req_ack` and `req_err` on the requester with `req_rval` = 16'hFFFF. A late `reg_ack` 3 cycles later has no effect.
- **Async reset:** assert `rst` mid-ISSUE, between clock edges. Expect `reg_vld` = 0 and `busy` = 0 immediately, no `req_ack`, and after release the next grant comes from `rr_ptr` = 0.
- **Ack/request overlap:** requester 0 keeps `req_vld` high through the cycle after `req_ack` while requester 3 is requesting. Expect requester 3 to be granted, with no duplicate grant to requester 0.
